// File: rtl/pc_fetch.sv
// Program-counter register and instruction-fetch sequencer: fetches the word at pc from BRAM,
// presents it with a valid/ack handshake and loads the next PC on acknowledge. Optional feature macro: PC_FETCH_HALT_EN.
module pc_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned BRAM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [15:0] pc,
  input  logic [15:0] pc_next,
  output logic [15:0] bram_addr,
  output logic        bram_rd,
  input  logic [15:0] bram_dout,
  output logic [15:0] ir,
  output logic        ir_valid,
  input  logic        ir_ack,
  output logic        busy,
  output logic        halted
);

  localparam int unsigned CW = 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic [15:0]     pc_nxt;
  logic [15:0]     ir_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;

  // BRAM always reads the architectural PC.
  assign bram_addr = pc;

  // State, datapath registers and registered status outputs decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      ir       <= 16'h0000;
      cnt      <= '0;
      bram_rd  <= 1'b0;
      ir_valid <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      ir       <= ir_nxt;
      cnt      <= cnt_nxt;
      bram_rd  <= (state_nxt == S_FETCH);
      ir_valid <= (state_nxt == S_HOLD);
      busy     <= (state_nxt != S_IDLE);
    end
  end

`ifdef PC_FETCH_HALT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) halted <= 1'b0;
    else     halted <= (state_nxt == S_HALT);
  end
`else
  assign halted = 1'b0;
`endif

  // Next-state and datapath update.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ir_nxt    = ir;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        cnt_nxt   = CW'(BRAM_LAT - 1);
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (cnt == '0) begin
          ir_nxt    = bram_dout;
          state_nxt = S_HOLD;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      S_HOLD: begin
        if (ir_ack) begin
`ifdef PC_FETCH_HALT_EN
          // Jump-to-self parks the sequencer instead of spinning on the same word.
          if (pc_next == pc) begin
            state_nxt = S_HALT;
          end else begin
            pc_nxt    = pc_next;
            state_nxt = S_FETCH;
          end
`else
          pc_nxt    = pc_next;
          state_nxt = S_FETCH;
`endif
        end
      end
      S_HALT: begin
`ifdef PC_FETCH_HALT_EN
        if (start) state_nxt = S_FETCH;
`else
        state_nxt = S_IDLE;
`endif
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Program-counter register and instruction-fetch sequencer for the 16-bit CPU. It holds the architectural PC, drives the PC to the next-PC mux's data input, and reads the instruction word at that PC from block RAM. It presents the word to the engine with a valid/ack handshake, then loads the mux's selected next PC (PC+1 or the immediate target) on acknowledge. It sits directly downstream of the next-PC mux and upstream of the decode engine.

## Interface
- Reset is asynchronous and active-high; the block uses one clock.
- Parameters:
  - RESET_PC, 16'h0000: PC value after reset.
  - BRAM_LAT, 1: BRAM read latency in cycles (legal 1..4).
- Ports:
  - clk  in  1: the only clock; all state updates on its rising edge.
  - rst  in  1: asynchronous, active-high reset.
  - start  in  1: begin fetching from the current PC. Sampled only in IDLE (and in HALT when enabled).
  - pc  out  16: current PC; feeds the next-PC mux data input.
  - pc_next  in  16: next-PC mux output. Sampled only in the acknowledge cycle.
  - bram_addr  out  16: BRAM read address; equals pc.
  - bram_rd  out  1: BRAM read strobe, one cycle per fetch.
  - bram_dout  in  16: BRAM read data.
  - ir  out  16: captured instruction word.
  - ir_valid  out  1: ir holds the word fetched from pc.
  - ir_ack  in  1: engine consumes ir; takes effect only when ir_valid=1.
  - busy  out  1: state is not IDLE.
  - halted  out  1: jump-to-self detected. Tied 0 when PC_FETCH_HALT_EN is undefined.

## Operation
- States: IDLE, FETCH, WAIT, HOLD, plus HALT when the macro is enabled.
- IDLE: bram_rd=0, ir_valid=0. start=1 -> FETCH.
- FETCH: one cycle; bram_rd=1 with bram_addr=pc -> WAIT. The wait counter is loaded with BRAM_LAT-1.
- WAIT: bram_rd=0.
  - Counter nonzero: decrement.
  - Counter zero: capture bram_dout into ir at this edge -> HOLD.
- HOLD: ir_valid=1; ir is held stable.
  - ir_valid & ir_ack: pc <= pc_next, ir_valid drops -> FETCH.
  - Otherwise stay in HOLD indefinitely (stall).
- ir_ack outside HOLD: ignored. start outside IDLE/HALT: ignored.
- PC arithmetic is plain 16-bit. No range check: 16'hFFFF+1 from the mux is 16'h0000, which is loaded and fetched normally.
- bram_addr is combinationally equal to pc. pc changes only at the acknowledge edge or at reset.

## Timing
- Reset values:
  - pc=RESET_PC, bram_addr=RESET_PC.
  - ir=16'h0000, ir_valid=0, bram_rd=0, busy=0, halted=0.
  - state=IDLE.
- Reset asserted mid-operation (any state): the values above apply immediately. Any in-flight BRAM data is discarded, and the block stays in IDLE after release until start.
- Fetch latency: FETCH in cycle t; ir captured at the end of cycle t+BRAM_LAT; ir_valid=1 from cycle t+BRAM_LAT+1.
- Ack in cycle h: new pc visible in h+1, which is the next FETCH cycle.
- Peak throughput: one instruction per BRAM_LAT+2 cycles, with ack in the first HOLD cycle.
- start to first bram_rd: start high in IDLE at cycle s -> FETCH in s+1.

## Configuration
- PC_FETCH_HALT_EN defined:
  - On acknowledge with pc_next == pc, pc is unchanged, state -> HALT and halted=1.
  - HALT: ir_valid=0, bram_rd=0, busy=1.
  - start=1 in HALT clears halted and goes to FETCH, re-fetching the same pc.
- PC_FETCH_HALT_EN undefined: a jump-to-self refetches the same address every BRAM_LAT+2 cycles forever, and halted is constant 0.

## Test plan
- Reset release, start held low 5 cycles -> pc=16'h0000, bram_rd never 1, busy=0, ir_valid=0.
- BRAM_LAT=1, start, ack every HOLD cycle with pc_next=pc+1, BRAM returns addr^16'hA5A5 -> bram_rd at cycles 1,4,7; ir=16'hA5A5,16'hA5A4,16'hA5A7 for pc 0,1,2.
- BRAM_LAT=3, ir_ack withheld 6 cycles -> ir_valid held 6+ cycles, ir stable, no extra bram_rd; pc advances only on the ack edge.
- pc at 16'hFFFF, ack with pc_next=16'h0000 -> next bram_addr=16'h0000, ir from address 0.
- rst pulsed during WAIT -> next cycle ir_valid=0, pc=RESET_PC, state IDLE; late bram_dout not captured.
- PC_FETCH_HALT_EN defined, pc=16'h0010, ack with pc_next=16'h0010 -> halted=1, no bram_rd; start -> halted=0, refetch 16'h0010.
